// File: rtl/fifo_pkg.sv
// Shared definitions for FIFO users: address-width helper and the error-flag pair
// carried on status buses.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read address.
// Kept separate so a vendor RAM macro can be dropped in.
module fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_watermark.sv
// Parametrised single-clock FIFO with exact occupancy, watermark flags, sticky
// overflow/underflow and selectable first-word-fall-through read mode.
module fifo_watermark
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = 0,
  localparam int unsigned AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  err_flags_t       err_q, err_d;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] ram_rdata;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == (AW+1)'(DEPTH));
    almost_full  = (count_q >= (AW+1)'(AF_LEVEL));
    almost_empty = (count_q <= (AW+1)'(AE_LEVEL));
    count        = count_q;
    overflow     = err_q.overflow;
    underflow    = err_q.underflow;
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err wins.
    err_d.overflow  = (wr_en & ~wr_ok) | (err_q.overflow & ~clr_err);
    err_d.underflow = (rd_en & ~rd_ok) | (err_q.underflow & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_ok & ~rst),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = rd_ok ? ram_rdata : rd_data_q;
      rd_valid_d = rd_ok;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_watermark.sv
// Bench for fifo_watermark: registered-read instance checked through a data scoreboard,
// plus a small fall-through instance.
module tb_fifo_watermark;

  logic       clk;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  fifo_watermark #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  fifo_watermark #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)
  ) u_dut_fwft (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (f_wr_en),
    .wr_data     (f_wr_data),
    .rd_en       (f_rd_en),
    .rd_data     (f_rd_data),
    .rd_valid    (f_rd_valid),
    .full        (f_full),
    .empty       (f_empty),
    .almost_full (f_af),
    .almost_empty(f_ae),
    .count       (f_count),
    .overflow    (f_ovf),
    .underflow   (f_udf),
    .clr_err     (f_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every word presented on the registered-read port must match the next expected one.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got %0h want no word", rd_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (rd_data !== exp_v) begin
          bad++;
          $display("FAIL sb_data: got %0h want %0h", rd_data, exp_v);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b0; wr_data = 8'h55;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = 8'h00;

    // Reset with both requests high
    tick(); tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'({overflow, underflow}), 0);
    chk("rst_valid", 32'(rd_valid), 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
      chk("fill_ae", 32'(almost_empty), (i + 1 <= 4) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 15) ? 1 : 0);
    end
    wr_data = 8'hFF;
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    wr_en = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Simultaneous read+write at full
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
    exp_q.push_back(8'h00);
    tick();
    wr_en = 1'b0;
    chk("rw_full_count", 32'(count), 16);
    chk("rw_full_ovf", 32'(overflow), 0);

    // Drain: 0x01..0x0F then 0xA5
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back((i < 15) ? 8'(i + 1) : 8'hA5);
      tick();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    tick();
    chk("idle_valid", 32'(rd_valid), 0);

    // Simultaneous read+write at empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_empty_count", 32'(count), 1);
    chk("rw_empty_udf", 32'(underflow), 1);
    chk("rw_empty_valid", 32'(rd_valid), 0);

    // Sticky errors
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("udf_clr", 32'(underflow), 0);
    rd_en = 1'b1;
    exp_q.push_back(8'h11);
    tick();
    clr_err = 1'b1;
    tick();
    chk("udf_set_wins", 32'(underflow), 1);
    rd_en = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("udf_clr2", 32'(underflow), 0);

    // Wrap-around at count 3
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'(8'h23 + i);
      exp_q.push_back(8'(8'h20 + i));
      tick();
      chk("wrap_count", 32'(count), 3);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'h48 + i));
      tick();
    end
    rd_en = 1'b0;
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_err", 32'({overflow, underflow}), 0);
    tick();

    // Reset discards stored words
    wr_en = 1'b1; wr_data = 8'h77;
    tick(); tick();
    rst = 1'b1; rd_en = 1'b1;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);

    // Fall-through instance
    f_wr_en = 1'b1; f_wr_data = 8'h3C;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_valid", 32'(f_rd_valid), 1);
    chk("fwft_data", 32'(f_rd_data), 32'h3C);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    chk("fwft_pop_valid", 32'(f_rd_valid), 0);
    chk("fwft_pop_count", 32'(f_count), 0);

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_watermark.md
# fifo_watermark

Parametrised single-clock FIFO for all intra-block buffering. It replaces the fixed 16×8 FIFO with configurable width and depth, and adds:
- an exact occupancy count;
- programmable almost-full/almost-empty watermarks;
- sticky, separately reported overflow/underflow errors;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH-1
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1
- FWFT, 0, 0 = registered read mode, 1 = first-word-fall-through
- Derived localparam: AW = log2(DEPTH)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word (meaning depends on FWFT, see Operation)
- full, empty  out  1  registered occupancy flags
- almost_full, almost_empty  out  1  registered watermark flags
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  clears overflow and underflow

## Operation
- **State:** wr_ptr and rd_ptr (AW bits each, wrap naturally from DEPTH-1 to 0), count (AW+1 bits). All flags decode from the registered count.
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_LEVEL)
  - almost_empty = (count ≤ AE_LEVEL)
- **Read accept:** rd_ok = rd_en & ~empty.
- **Write accept:** wr_ok = wr_en & (~full | rd_ok). A simultaneous read and write on a full FIFO both succeed.
- **Write on empty with rd_en:** the write is accepted and the read is rejected (underflow sets). Data never bypasses memory.
- **Count update:**
  - count += 1 on wr_ok & ~rd_ok
  - count −= 1 on rd_ok & ~wr_ok
  - count is unchanged otherwise
- **Errors:**
  - overflow sets on wr_en & ~wr_ok.
  - underflow sets on rd_en & ~rd_ok.
  - Both flags hold until rst, or until clr_err is high in a cycle with no new error of that kind. On simultaneous clr_err and a new error, set wins.
- **Rejected operations** never change pointers, count or memory.
- **FWFT=0 (registered read):**
  - On rd_ok, rd_data <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- **FWFT=1 (fall-through):**
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en acts as an acknowledge of the word currently shown.
- **Reset values:** rd_data 0, rd_valid 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, pointers 0. Memory contents are not reset.
- **Reset mid-operation:** rst overrides wr_en and rd_en in the same cycle. All stored words are discarded.

## Timing
- **Write to flags:** a write at edge N is visible in count and the flags after edge N.
- **Empty-to-readable latency:**
  - A word written at edge N can be popped by rd_en sampled at edge N+1.
  - FWFT=0: the word appears on rd_data after edge N+1 (write→data 2 cycles).
  - FWFT=1: rd_data shows the word after edge N (1 cycle).
- **Read latency:**
  - FWFT=0: 1 cycle from rd_en to rd_data/rd_valid.
  - FWFT=1: 0 cycles; the next word is shown after the popping edge.
- **Throughput:** one write and one read per cycle sustained at any occupancy, including full (simultaneous read+write) and empty (writes only).

## Structure
- **Shared package fifo_pkg:**
  - function clog2 for AW;
  - typedef for the error-flag pair {overflow, underflow} so status buses stay consistent across FIFO users.
- **Sub-module fifo_ram:**
  - simple dual-port WIDTH×DEPTH memory with synchronous write and asynchronous read address;
  - keeps the storage separate so a vendor RAM can replace it.
- **Top level** holds pointers, count, flag decode, error logic and the FWFT generate branch.

## Test plan
All scenarios use DEPTH=16, WIDTH=8, AF=12, AE=4 unless noted.
- **Reset:** assert rst 2 cycles with wr_en=rd_en=1 → count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0, rd_valid=0.
- **Fill then drain (FWFT=0):**
  - Write 0x00..0x0F in 16 cycles → almost_full after the 12th write, full after the 16th, count=16.
  - 17th write → overflow=1, count stays 16.
  - Drain → rd_data 0x00..0x0F in order, each 1 cycle after rd_en; empty after the 16th read.
- **Simultaneous read+write:**
  - At full: rd_en=wr_en=1 with 0xA5 → count stays 16, overflow stays 0, 0xA5 is read last.
  - At empty: both high → count=1, underflow=1.
- **Wrap-around:** 40 cycles of continuous write+read at count=3 → pointers wrap twice, output sequence equals input sequence delayed by 3 words, no error flag.
- **Sticky errors:** underflow set, then clr_err=1 with no error → cleared next edge. clr_err together with a new rejected read → underflow remains 1.
- **FWFT=1:** write 0x3C into empty → rd_data=0x3C and rd_valid=1 one cycle later without rd_en. Pop → rd_valid=0 the next cycle.
